cmplx_square_core: RTL
======================

# cmplx_square_core

Sequential fixed-point complex squarer: computes (x + jy)² = (x² − y²) + j·2xy for one 16-bit signed sample per start pulse. It is the inverse-direction companion to the complex square-root core. It uses the same start/valid handshake and the same x_in/y_in operand naming, so a bench or datapath can chain sqrt → square for round-trip checking. It is implemented as a single shared shift-add engine that produces all three partial products in parallel over FRAC-independent 16 iterations.

## Interface
- FRAC, default 8: fraction bits of the signed input and output format (Q(16−FRAC).FRAC); legal range 1..14.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; x_in/y_in are sampled in the same cycle.
- x_in  in  16  real part, signed two's complement, Q(16−FRAC).FRAC.
- y_in  in  16  imaginary part, same format.
- sq_real_out  out  16  x² − y², signed, same format; held until the next result.
- sq_img_out  out  16  2xy, signed, same format; held until the next result.
- sq_valid  out  1  one-cycle pulse when the outputs update.
- busy  out  1  high while a computation is in flight.

## Operation
- States: IDLE, MUL, FIN.
- IDLE with start=1 →
  - capture |x| and |y| as 16-bit unsigned (|−32768| = 32768 is representable);
  - capture prod_sign = x_in[15] ^ y_in[15];
  - clear the accumulators aa, bb and ab (32-bit unsigned) and counter cnt;
  - go to MUL.
- MUL, one multiplier bit per cycle, LSB first, over 16 cycles (cnt 0..15):
  - add |x|<<cnt to aa if |x|[cnt] is set;
  - add |y|<<cnt to bb if |y|[cnt] is set;
  - add |y|<<cnt to ab if |x|[cnt] is set.
  - At cnt=15, go to FIN.
- FIN:
  - re = aa − bb, as a 33-bit signed value.
  - im = ±(ab<<1), as a 34-bit signed value, negated when prod_sign=1.
  - Scale both by an arithmetic shift right of FRAC (truncation toward −∞; no rounding).
  - Reduce to 16 bits per the Configuration section, register sq_real_out/sq_img_out, pulse sq_valid, and return to IDLE.
- start while busy=1 is ignored; the operands are not queued.
- A zero operand is not special-cased; it still takes the full latency.
- Reset, at any time including mid-MUL:
  - state → IDLE, accumulators cleared, the computation in flight is discarded with no sq_valid;
  - sq_real_out=0, sq_img_out=0, sq_valid=0, busy=0.

## Timing
- start high in cycle 0 → busy high in cycles 1–17 → sq_valid high in cycle 18 only, with outputs valid from cycle 18 onward.
- Latency 18 cycles. busy=0 in cycle 18, so a new start may be issued in the same cycle as sq_valid, giving one result per 18 cycles.
- Outputs change only in the sq_valid cycle.
- start in cycle 0 with rst in cycle 0: reset wins and no computation starts.

## Configuration
- CMPLX_SQ_SAT_EN defined: each scaled result outside [−32768, 32767] clamps to 0x8000 or 0x7FFF, per component.
- Undefined: each component wraps by taking the low 16 bits of the scaled result.
- The macro has no effect on latency or handshake.

## Test plan
- FRAC=8, x=0x0180 (1.5), y=0x0080 (0.5) → sq_valid exactly 18 cycles after start, real=0x0200, img=0x0180.
- x=0xFF00 (−1.0), y=0x0200 (2.0) → real=0xFD00, img=0xFC00; back-to-back start in the sq_valid cycle is accepted and the second result arrives 18 cycles later.
- x=0x0000, y=0x0001 → real=0xFFFF (floor of −1/256), img=0x0000.
- x=0x7FFF, y=0x0000 → with CMPLX_SQ_SAT_EN real=0x7FFF, without it real=0xFF00; img=0x0000 in both builds.
- x=0x8000, y=0x8000 → real=0x0000; img=0x7FFF saturated, or 0x0000 wrapped.
- start pulses issued during busy are ignored (exactly one sq_valid); rst asserted in cycle 8 → no sq_valid, outputs read 0 and busy=0 in the cycle after the reset.

Source files
------------

// File: rtl/cmplx_square_core.sv
// Sequential fixed-point complex squarer: (x + jy)^2 = (x^2 - y^2) + j*2xy via a 16-cycle shift-add engine.
// Define CMPLX_SQ_SAT_EN to clamp out-of-range results; otherwise each component wraps to 16 bits.
module cmplx_square_core #(
    parameter int unsigned FRAC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic [15:0] sq_real_out,
    output logic [15:0] sq_img_out,
    output logic        sq_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t      state, state_next;
    logic [15:0] abs_x, abs_y;
    logic        prod_sign;
    logic [31:0] aa, bb, ab;
    logic [3:0]  cnt;

    logic signed [32:0] re_full;
    logic signed [33:0] im_mag, im_full;
    logic signed [33:0] re_scaled, im_scaled;

    function automatic logic [15:0] reduce(input logic signed [33:0] v);
`ifdef CMPLX_SQ_SAT_EN
        if (v > 34'sd32767)       return 16'h7fff;
        else if (v < -34'sd32768) return 16'h8000;
        else                      return v[15:0];
`else
        return v[15:0];
`endif
    endfunction

    // Magnitude of -32768 is 0x8000, which fits as an unsigned 16-bit value.
    function automatic logic [15:0] magnitude(input logic [15:0] v);
        return v[15] ? 16'(-v) : v;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            MUL:     if (cnt == 4'd15) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign re_full   = $signed({1'b0, aa}) - $signed({1'b0, bb});
    assign im_mag    = $signed({1'b0, ab, 1'b0});
    assign im_full   = prod_sign ? -im_mag : im_mag;
    assign re_scaled = 34'(re_full) >>> FRAC;
    assign im_scaled = im_full >>> FRAC;
    assign busy      = (state != IDLE);

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_x       <= '0;
            abs_y       <= '0;
            prod_sign   <= 1'b0;
            aa          <= '0;
            bb          <= '0;
            ab          <= '0;
            cnt         <= '0;
            sq_real_out <= '0;
            sq_img_out  <= '0;
            sq_valid    <= 1'b0;
        end else begin
            sq_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    abs_x     <= magnitude(x_in);
                    abs_y     <= magnitude(y_in);
                    prod_sign <= x_in[15] ^ y_in[15];
                    aa        <= '0;
                    bb        <= '0;
                    ab        <= '0;
                    cnt       <= '0;
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first; x drives both aa and ab.
                    if (abs_x[cnt]) begin
                        aa <= aa + ({16'd0, abs_x} << cnt);
                        ab <= ab + ({16'd0, abs_y} << cnt);
                    end
                    if (abs_y[cnt]) bb <= bb + ({16'd0, abs_y} << cnt);
                    cnt <= cnt + 4'd1;
                end
                FIN: begin
                    sq_real_out <= reduce(re_scaled);
                    sq_img_out  <= reduce(im_scaled);
                    sq_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
